// File: rtl/mix_columns_engine_pkg.sv
// Shared types, constants and GF(2^8) helpers for the MixColumns engine.
package mix_columns_engine_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned STATE_W  = 128;
    localparam int unsigned NUM_COLS = 4;

    localparam logic [BYTE_W-1:0] AES_POLY = 8'h1b;

    typedef logic [COL_W-1:0]   column_t;
    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by one of the MixColumns constants using xtime chains only.
    function automatic logic [BYTE_W-1:0] gmul(input logic [BYTE_W-1:0] b,
                                               input logic [3:0]        k);
        logic [BYTE_W-1:0] x2;
        logic [BYTE_W-1:0] x4;
        logic [BYTE_W-1:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            4'd2:    return x2;
            4'd3:    return x2 ^ b;
            4'd9:    return x8 ^ b;
            4'd11:   return x8 ^ x2 ^ b;
            4'd13:   return x8 ^ x4 ^ b;
            4'd14:   return x8 ^ x4 ^ x2;
            default: return b;
        endcase
    endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Block handshake bundle: input block channel and result channel.
interface mix_columns_engine_if;
    import mix_columns_engine_pkg::*;

    logic   in_valid;
    logic   in_ready;
    logic   in_inv;
    state_t in_state;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;

    modport master (
        output in_valid, in_inv, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_inv, in_state, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface

// File: rtl/mix_columns_engine_mix_column_unit.sv
// Single-column MixColumns / InvMixColumns, purely combinational.
module mix_column_unit
    import mix_columns_engine_pkg::*;
(
    input  column_t column,
    input  logic    inv,
    output column_t mixed_c
);

    logic [BYTE_W-1:0] a [NUM_COLS];

    // Split the column word into rows; row 0 sits in the MSB.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r] = column[31-8*r -: 8];
        end
    end

    // Each output row is the circulant matrix row rotated by the row index.
    always_comb begin
        logic [BYTE_W-1:0] fwd_b;
        logic [BYTE_W-1:0] inv_b;
        mixed_c = '0;
        fwd_b   = '0;
        inv_b   = '0;
        for (int r = 0; r < 4; r++) begin
            fwd_b = gmul(a[r], 4'd2) ^ gmul(a[(r+1)%4], 4'd3)
                  ^ a[(r+2)%4] ^ a[(r+3)%4];
            inv_b = gmul(a[r], 4'd14) ^ gmul(a[(r+1)%4], 4'd11)
                  ^ gmul(a[(r+2)%4], 4'd13) ^ gmul(a[(r+3)%4], 4'd9);
            mixed_c[31-8*r -: 8] = inv ? inv_b : fwd_b;
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative MixColumns / InvMixColumns over a 128-bit state, LANES columns per cycle.
module mix_columns_engine
    import mix_columns_engine_pkg::*;
#(
    parameter int unsigned LANES  = 1,
    parameter bit          INV_EN = 1'b1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    mix_columns_engine_if.slave  bus
);

    localparam int unsigned IDX_W = 2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("mix_columns_engine: LANES must be 1, 2 or 4");
    end

    fsm_state_t        fsm_q;
    state_t            work_q;
    state_t            work_mixed;
    logic [IDX_W-1:0]  col_idx_q;
    logic              inv_q;
    logic              out_valid_q;
    state_t            out_state_q;
    logic              lane_inv;

    logic [IDX_W-1:0]  lane_idx [LANES];
    column_t           lane_in  [LANES];
    column_t           lane_out [LANES];

    // Inverse logic collapses away when the mode is not supported.
    assign lane_inv = INV_EN & inv_q;

    // Lane l works on column col_idx+l; col_idx is always a multiple of LANES.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = col_idx_q + IDX_W'(l);
        assign lane_in[l]  = work_q[{~lane_idx[l], 5'd0} +: COL_W];

        mix_column_unit u_unit (
            .column  (lane_in[l]),
            .inv     (lane_inv),
            .mixed_c (lane_out[l])
        );
    end

    // Working register with the active columns replaced in place.
    always_comb begin
        work_mixed = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_mixed[{~lane_idx[l], 5'd0} +: COL_W] = lane_out[l];
        end
    end

    // Control FSM, working register and registered result channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            work_q      <= '0;
            col_idx_q   <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q    <= bus.in_state;
                        inv_q     <= bus.in_inv & INV_EN;
                        col_idx_q <= '0;
                        fsm_q     <= BUSY;
                    end
                end
                BUSY: begin
                    work_q    <= work_mixed;
                    col_idx_q <= col_idx_q + IDX_W'(LANES);
                    if (col_idx_q == IDX_W'(NUM_COLS - LANES)) begin
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                        out_state_q <= work_mixed;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            work_q    <= bus.in_state;
                            inv_q     <= bus.in_inv & INV_EN;
                            col_idx_q <= '0;
                            fsm_q     <= BUSY;
                        end else begin
                            fsm_q <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // A result leaving DONE frees the engine on the same edge.
    assign bus.in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;

endmodule
